// File: rtl/dram_port_arbiter_if.sv
// Bundle of the four-core request bus and the single-port synchronous DRAM bus
// seen by dram_port_arbiter; slave is the arbiter side, master is the cores/DRAM side.
interface dram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic [3:0]          i_req;
  logic [3:0]          i_we;
  logic [4*ADDR_W-1:0] i_addr;
  logic [4*DATA_W-1:0] i_wdata;
  logic [3:0]          o_gnt;
  logic [3:0]          o_rvalid;
  logic [DATA_W-1:0]   o_rdata;
  logic [ADDR_W-1:0]   o_mem_addr;
  logic [DATA_W-1:0]   o_mem_wdata;
  logic                o_mem_rden;
  logic                o_mem_wren;
  logic [DATA_W-1:0]   i_mem_q;
  logic                o_busy;

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_mem_q,
    output o_gnt, o_rvalid, o_rdata, o_mem_addr, o_mem_wdata,
           o_mem_rden, o_mem_wren, o_busy
  );

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_mem_q,
    input  o_gnt, o_rvalid, o_rdata, o_mem_addr, o_mem_wdata,
           o_mem_rden, o_mem_wren, o_busy
  );
endinterface

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one synchronous DRAM port between four cores;
// one transaction outstanding at a time, every output registered.
module dram_port_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  dram_port_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          last_q, last_d;
  logic                lat_we_q, lat_we_d;
  logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;

  logic [3:0]          gnt_q, gnt_d;
  logic [3:0]          rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                rden_q, rden_d;
  logic                wren_q, wren_d;
  logic                busy_q, busy_d;

  logic [1:0]          sel_c;
  logic                any_req_c;

  // Round-robin pick: scan last+4 down to last+1 so the nearest successor wins
  always_comb begin
    sel_c     = last_q;
    any_req_c = |bus.i_req;
    for (int i = 4; i >= 1; i--) begin
      if (bus.i_req[2'(last_q + 2'(i))]) sel_c = 2'(last_q + 2'(i));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 2'd3;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rden_q      <= 1'b0;
      wren_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rden_q      <= rden_d;
      wren_q      <= wren_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    case (state_q)
      IDLE: begin
        if (any_req_c) begin
          state_d     = ISSUE;
          last_d      = sel_c;
          lat_we_d    = bus.i_we[sel_c];
          lat_addr_d  = bus.i_addr[sel_c*ADDR_W +: ADDR_W];
          lat_wdata_d = bus.i_wdata[sel_c*DATA_W +: DATA_W];
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = lat_we_q ? IDLE : WAIT;
      end
      WAIT: begin
        // Last WAIT cycle is the one where i_mem_q carries the read data
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered off the next state so they line up with that state
  always_comb begin
    gnt_d       = '0;
    rvalid_d    = '0;
    rden_d      = 1'b0;
    wren_d      = 1'b0;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = (state_d != IDLE);
    if (state_d == ISSUE) begin
      gnt_d       = 4'b0001 << last_d;
      mem_addr_d  = lat_addr_d;
      mem_wdata_d = lat_wdata_d;
      wren_d      = lat_we_d;
      rden_d      = !lat_we_d;
    end
    if (state_d == RESP) begin
      rvalid_d = 4'b0001 << last_q;
      rdata_d  = bus.i_mem_q;
    end
  end

  assign bus.o_gnt       = gnt_q;
  assign bus.o_rvalid    = rvalid_q;
  assign bus.o_rdata     = rdata_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_mem_rden  = rden_q;
  assign bus.o_mem_wren  = wren_q;
  assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter: four-core stimulus plus a fixed-latency
// synchronous DRAM model; inputs driven and outputs checked on the falling edge.
module tb_dram_port_arbiter;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RD_LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wren_cnt = 0;
  int   wren_base;

  always #5 clk = ~clk;

  dram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // DRAM contents: 0x0040 holds 0x5C, everything else addr[7:0]^0xC3
  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    return (a == 16'h0040) ? 8'h5C : (a[7:0] ^ 8'hC3);
  endfunction

  logic [DATA_W-1:0] mem_pipe [RD_LAT];
  always @(posedge clk) begin
    mem_pipe[0] <= bus.o_mem_rden ? mem_rd(bus.o_mem_addr) : 8'h00;
    for (int i = 1; i < int'(RD_LAT); i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign bus.i_mem_q = mem_pipe[RD_LAT-1];

  always @(negedge clk) if (bus.o_mem_wren === 1'b1) wren_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_core(input int k, input logic we, input logic [15:0] a, input logic [7:0] d);
    bus.i_req[k] = 1'b1;
    bus.i_we[k]  = we;
    bus.i_addr[k*ADDR_W +: ADDR_W]  = a;
    bus.i_wdata[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic drop(input int k);
    bus.i_req[k] = 1'b0;
  endtask

  initial begin
    bus.i_req   = '0;
    bus.i_we    = '0;
    bus.i_addr  = '0;
    bus.i_wdata = '0;
    cyc(); cyc();
    chk("rst_gnt",    32'(bus.o_gnt), 32'h0);
    chk("rst_rvalid", 32'(bus.o_rvalid), 32'h0);
    chk("rst_rden",   32'(bus.o_mem_rden), 32'h0);
    chk("rst_wren",   32'(bus.o_mem_wren), 32'h0);
    chk("rst_busy",   32'(bus.o_busy), 32'h0);
    chk("rst_rdata",  32'(bus.o_rdata), 32'h0);
    chk("rst_maddr",  32'(bus.o_mem_addr), 32'h0);
    chk("rst_mwdata", 32'(bus.o_mem_wdata), 32'h0);

    // Single write from core 0
    rst_n = 1'b1;
    set_core(0, 1'b1, 16'h0123, 8'hA5);
    cyc();
    chk("wr_gnt",    32'(bus.o_gnt), 32'h1);
    chk("wr_wren",   32'(bus.o_mem_wren), 32'h1);
    chk("wr_rden",   32'(bus.o_mem_rden), 32'h0);
    chk("wr_addr",   32'(bus.o_mem_addr), 32'h0123);
    chk("wr_wdata",  32'(bus.o_mem_wdata), 32'hA5);
    chk("wr_busy",   32'(bus.o_busy), 32'h1);
    drop(0);
    cyc();
    chk("wr_gnt_off",  32'(bus.o_gnt), 32'h0);
    chk("wr_wren_off", 32'(bus.o_mem_wren), 32'h0);
    chk("wr_idle",     32'(bus.o_busy), 32'h0);
    chk("wr_addr_hold", 32'(bus.o_mem_addr), 32'h0123);
    cyc();
    chk("wr_no_rvalid", 32'(bus.o_rvalid), 32'h0);

    // Single read from core 2 at 0x0040
    set_core(2, 1'b0, 16'h0040, 8'h00);
    cyc();
    chk("rd_gnt",  32'(bus.o_gnt), 32'h4);
    chk("rd_rden", 32'(bus.o_mem_rden), 32'h1);
    chk("rd_wren", 32'(bus.o_mem_wren), 32'h0);
    chk("rd_addr", 32'(bus.o_mem_addr), 32'h0040);
    drop(2);
    cyc();
    chk("rd_c2_rden",   32'(bus.o_mem_rden), 32'h0);
    chk("rd_c2_busy",   32'(bus.o_busy), 32'h1);
    chk("rd_c2_rvalid", 32'(bus.o_rvalid), 32'h0);
    cyc();
    chk("rd_c3_rvalid", 32'(bus.o_rvalid), 32'h0);
    cyc();
    chk("rd_rvalid", 32'(bus.o_rvalid), 32'h4);
    chk("rd_rdata",  32'(bus.o_rdata), 32'h5C);
    cyc();
    chk("rd_rvalid_off", 32'(bus.o_rvalid), 32'h0);
    chk("rd_rdata_hold", 32'(bus.o_rdata), 32'h5C);
    chk("rd_idle",       32'(bus.o_busy), 32'h0);

    // Four simultaneous writes straight out of reset
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    wren_base = wren_cnt;
    for (int k = 0; k < 4; k++) set_core(k, 1'b1, 16'(16'h1000 + k), 8'(8'h10 + k));
    for (int g = 0; g < 4; g++) begin
      cyc();
      chk("all_gnt",   32'(bus.o_gnt), 32'(1) << g);
      chk("all_wren",  32'(bus.o_mem_wren), 32'h1);
      chk("all_rden",  32'(bus.o_mem_rden), 32'h0);
      chk("all_addr",  32'(bus.o_mem_addr), 32'h1000 + 32'(g));
      chk("all_wdata", 32'(bus.o_mem_wdata), 32'h10 + 32'(g));
      drop(g);
      cyc();
      chk("all_gap_gnt", 32'(bus.o_gnt), 32'h0);
    end
    cyc();
    chk("all_wren_pulses", 32'(wren_cnt - wren_base), 32'd4);

    // Fairness: after core 1, core 3 beats core 0
    set_core(1, 1'b1, 16'h3001, 8'h31);
    cyc();
    chk("fair_gnt1", 32'(bus.o_gnt), 32'h2);
    drop(1);
    cyc();
    set_core(0, 1'b1, 16'h3000, 8'h30);
    set_core(3, 1'b1, 16'h3003, 8'h33);
    cyc();
    chk("fair_gnt3",   32'(bus.o_gnt), 32'h8);
    chk("fair_wdata3", 32'(bus.o_mem_wdata), 32'h33);
    drop(3);
    cyc();
    chk("fair_gap", 32'(bus.o_gnt), 32'h0);
    cyc();
    chk("fair_gnt0",   32'(bus.o_gnt), 32'h1);
    chk("fair_wdata0", 32'(bus.o_mem_wdata), 32'h30);
    drop(0);
    cyc();

    // Core 1 write arrives while core 0 read is in WAIT
    set_core(0, 1'b0, 16'h0007, 8'h00);
    cyc();
    chk("pend_gnt0", 32'(bus.o_gnt), 32'h1);
    chk("pend_rden", 32'(bus.o_mem_rden), 32'h1);
    drop(0);
    cyc();
    set_core(1, 1'b1, 16'h2222, 8'h77);
    chk("pend_c2_gnt", 32'(bus.o_gnt), 32'h0);
    cyc();
    chk("pend_c3_gnt", 32'(bus.o_gnt), 32'h0);
    cyc();
    chk("pend_rvalid", 32'(bus.o_rvalid), 32'h1);
    chk("pend_rdata",  32'(bus.o_rdata), 32'hC4);
    chk("pend_c4_gnt", 32'(bus.o_gnt), 32'h0);
    cyc();
    chk("pend_c5_gnt",  32'(bus.o_gnt), 32'h0);
    chk("pend_c5_busy", 32'(bus.o_busy), 32'h0);
    cyc();
    chk("pend_gnt1",  32'(bus.o_gnt), 32'h2);
    chk("pend_wren",  32'(bus.o_mem_wren), 32'h1);
    chk("pend_addr1", 32'(bus.o_mem_addr), 32'h2222);
    drop(1);
    cyc();

    // Reset pulse during WAIT aborts the read; pending requests re-arbitrated from last=3
    set_core(2, 1'b0, 16'h0040, 8'h00);
    cyc();
    chk("abort_gnt2", 32'(bus.o_gnt), 32'h4);
    drop(2);
    cyc();
    chk("abort_wait_busy", 32'(bus.o_busy), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy",  32'(bus.o_busy), 32'h0);
    chk("abort_rdata", 32'(bus.o_rdata), 32'h0);
    chk("abort_maddr", 32'(bus.o_mem_addr), 32'h0);
    chk("abort_gnt",   32'(bus.o_gnt), 32'h0);
    set_core(1, 1'b1, 16'h4441, 8'h41);
    set_core(3, 1'b1, 16'h4443, 8'h43);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rearb_gnt1",   32'(bus.o_gnt), 32'h2);
    chk("rearb_rvalid", 32'(bus.o_rvalid), 32'h0);
    drop(1);
    cyc();
    chk("rearb_c2_rvalid", 32'(bus.o_rvalid), 32'h0);
    cyc();
    chk("rearb_gnt3",      32'(bus.o_gnt), 32'h8);
    chk("rearb_c3_rvalid", 32'(bus.o_rvalid), 32'h0);
    drop(3);
    cyc();
    chk("rearb_c4_rvalid", 32'(bus.o_rvalid), 32'h0);
    chk("rearb_rdata",     32'(bus.o_rdata), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
